// File: rtl/cpu_program_loader.sv
// Host-side program loader for the 8-bit CPU: holds a program image and streams it
// byte by byte over the CPU programming port, handshaking on ready/done.
module cpu_program_loader #(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    input  logic              ready_in,
    input  logic              done_in,
    output logic              programming,
    output logic [7:0]        prog_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StArm        = 3'd1;
    localparam logic [2:0] StWaitRdy    = 3'd2;
    localparam logic [2:0] StWaitRdyLow = 3'd3;
    localparam logic [2:0] StWaitDone   = 3'd4;
    localparam logic [2:0] StDone       = 3'd5;
    localparam logic [2:0] StError      = 3'd6;

    logic [7:0]        image_q [RAM_BYTES];
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        prog_q, prog_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              wait_st, tmo_hit;

    assign busy        = (state_q == StArm) || wait_st;
    assign programming = busy;
    assign done        = (state_q == StDone);
    assign error       = (state_q == StError);
    assign prog_data   = prog_q;
    assign byte_count  = cnt_q;

    assign wait_st = (state_q == StWaitRdy) || (state_q == StWaitRdyLow) ||
                     (state_q == StWaitDone);
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));
    assign ptr_inc = (ptr_q == ADDR_W'(RAM_BYTES - 1)) ? '0 : ptr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (img_we && !busy) begin
            image_q[img_addr] <= img_data;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        prog_d  = prog_q;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StArm;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    // A write landing on this edge must be what the load presents first.
                    prog_d  = (img_we && img_addr == '0) ? img_data : image_q[0];
                end
            end
            StArm: begin
                state_d = done_in ? StError : StWaitRdy;
            end
            StWaitRdy: begin
                if (done_in) begin
                    state_d = StError;
                end else if (ready_in) begin
                    state_d = StWaitRdyLow;
                    ptr_d   = ptr_inc;
                    cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                    prog_d  = image_q[ptr_inc];
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StWaitRdyLow: begin
                if (done_in) begin
                    state_d = StError;
                end else if (!ready_in) begin
                    state_d = (cnt_q == (ADDR_W + 1)'(RAM_BYTES)) ? StWaitDone : StWaitRdy;
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StWaitDone: begin
                if (done_in) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counter measures time spent in the current wait state only.
        if (state_d != state_q || !wait_st) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            prog_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            prog_q  <= prog_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: a CPU model pulses ready/done, a scoreboard
// checks each byte presented at a ready rising edge, status is checked inline.
module tb_cpu_program_loader;

    localparam int unsigned RamBytes = 16;
    localparam int unsigned AddrW    = 4;

    logic             clk = 1'b0;
    logic             rst, start, img_we, ready_in, done_in;
    logic [AddrW-1:0] img_addr;
    logic [7:0]       img_data;
    logic             programming, busy, done, error;
    logic [7:0]       prog_data;
    logic [AddrW:0]   byte_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] img_model [RamBytes];
    logic [7:0] exp_q [$];
    int         exp_ptr = 0;

    always #5 clk = ~clk;

    cpu_program_loader #(
        .RAM_BYTES(RamBytes),
        .ADDR_W   (AddrW),
        .TIMEOUT  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_data   (img_data),
        .ready_in   (ready_in),
        .done_in    (done_in),
        .programming(programming),
        .prog_data  (prog_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_img(input int addr, input logic [7:0] data);
        img_we   = 1'b1;
        img_addr = AddrW'(addr);
        img_data = data;
        img_model[addr] = data;
        tick();
        img_we = 1'b0;
    endtask

    // Start pulse, then the ARM cycle; returns with the DUT in WAIT_RDY.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_ptr = 0;
    endtask

    task automatic cpu_byte();
        exp_q.push_back(img_model[exp_ptr]);
        exp_ptr = (exp_ptr + 1) % RamBytes;
        ready_in = 1'b1;
        tick();
        tick();
        ready_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".programming"}, 32'(programming), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".error"}, 32'(error), 32'd0);
        check({tag, ".prog_data"}, 32'(prog_data), 32'd0);
        check({tag, ".byte_count"}, 32'(byte_count), 32'd0);
    endtask

    // Scoreboard monitor: the CPU consumes prog_data when it raises ready.
    initial begin
        logic rdy_prev;
        logic [7:0] exp;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_in && !rdy_prev && programming) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %0h, expected no byte", prog_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (prog_data !== exp) begin
                        failures++;
                        $display("FAIL sb_byte: got %0h, expected %0h", prog_data, exp);
                    end
                end
            end
            rdy_prev = ready_in;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; img_we = 1'b0; ready_in = 1'b0; done_in = 1'b0;
        img_addr = '0; img_data = '0;
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < RamBytes; i++) write_img(i, 8'(i * 17));

        // Full load of 16 bytes
        do_start();
        check("load.busy", 32'(busy), 32'd1);
        check("load.programming", 32'(programming), 32'd1);
        for (int i = 0; i < RamBytes; i++) cpu_byte();
        check("load.wait_done_busy", 32'(busy), 32'd1);
        check("load.count16_pre", 32'(byte_count), 32'd16);
        pulse_done();
        check("load.done", 32'(done), 32'd1);
        check("load.programming_off", 32'(programming), 32'd0);
        check("load.byte_count", 32'(byte_count), 32'd16);
        check("load.prog_hold", 32'(prog_data), 32'h00);

        // Write to image[0] on the same edge as start: the new value is presented
        img_we = 1'b1; img_addr = '0; img_data = 8'h5A; start = 1'b1;
        img_model[0] = 8'h5A;
        tick();
        img_we = 1'b0; start = 1'b0;
        check("bypass.prog_data", 32'(prog_data), 32'h5A);
        check("bypass.programming", 32'(programming), 32'd1);
        tick();
        exp_ptr = 0;

        // Ready held high counts once
        exp_q.push_back(img_model[0]);
        exp_ptr = 1;
        ready_in = 1'b1;
        repeat (10) tick();
        ready_in = 1'b0;
        tick();
        check("held.byte_count", 32'(byte_count), 32'd1);
        check("held.prog_data", 32'(prog_data), 32'h11);

        // Early done after 5 bytes
        repeat (4) cpu_byte();
        pulse_done();
        check("early.error", 32'(error), 32'd1);
        check("early.programming", 32'(programming), 32'd0);
        check("early.byte_count", 32'(byte_count), 32'd5);
        repeat (3) tick();
        check("early.count_frozen", 32'(byte_count), 32'd5);

        // Timeout with no ready
        do_start();
        repeat (19) tick();
        check("tmo.not_yet", 32'(error), 32'd0);
        check("tmo.busy", 32'(busy), 32'd1);
        tick();
        check("tmo.error", 32'(error), 32'd1);
        check("tmo.byte_count", 32'(byte_count), 32'd0);

        // Reset mid-load
        do_start();
        repeat (7) cpu_byte();
        check("mid.count7", 32'(byte_count), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");

        // Reload with a write attempt while busy
        start = 1'b1;
        tick();
        start = 1'b0;
        img_we = 1'b1; img_addr = AddrW'(3); img_data = 8'hAA;
        tick();
        img_we = 1'b0;
        exp_ptr = 0;
        check("reload.prog_data", 32'(prog_data), 32'h5A);
        for (int i = 0; i < RamBytes; i++) cpu_byte();
        pulse_done();
        check("reload.done", 32'(done), 32'd1);

        do_start();
        for (int i = 0; i < RamBytes; i++) cpu_byte();
        pulse_done();
        check("second.done", 32'(done), 32'd1);
        check("second.byte_count", 32'(byte_count), 32'd16);

        tick();
        check("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Upstream feeder for the 8-bit CPU's programming port.
- Holds a RAM_BYTES-deep program image written by a host.
- On start, raises programming (CPU uio_in[0]) and streams one byte per CPU ready pulse on prog_data (CPU ui_in).
- Finishes when the CPU reports done_load; flags protocol violations and timeouts.

Parameters:
- RAM_BYTES, 16, program image depth; must match CPU RAM size.
- ADDR_W, 4, image address width; log2(RAM_BYTES).
- TIMEOUT, 1023, maximum cycles spent in any wait state before error.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a load; single-cycle pulse, sampled in IDLE/DONE/ERROR only.
- img_we  input  1  image write strobe; ignored while busy.
- img_addr  input  ADDR_W  image write address.
- img_data  input  8  image write data.
- ready_in  input  1  CPU ready_for_ui (uio_out[1]).
- done_in  input  1  CPU done_load (uio_out[2]).
- programming  output  1  to CPU uio_in[0].
- prog_data  output  8  to CPU ui_in; registered.
- busy  output  1  high in ARM/WAIT_RDY/WAIT_RDY_LOW/WAIT_DONE.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.
- byte_count  output  ADDR_W+1  bytes consumed this load.

Behaviour:
- Reset values:
  - State is IDLE.
  - programming, busy, done and error are 0.
  - prog_data = 0, byte_count = 0, read pointer = 0, timeout counter = 0.
  - Image contents are not cleared by rst.
- Image write: when img_we=1 and not busy, image[img_addr] <= img_data at the clock edge.
- IDLE / DONE / ERROR, start=1:
  - Next state ARM; pointer and byte_count cleared.
  - programming=1 and prog_data=image[0] from the next cycle (one-cycle latency).
- ARM: one cycle; goes to WAIT_RDY. Gives the CPU one cycle to see programming before any ready.
- WAIT_RDY, ready_in=1:
  - Byte consumed; pointer += 1 (wraps mod RAM_BYTES); byte_count += 1.
  - prog_data <= image[pointer+1] on the same edge.
  - Next state WAIT_RDY_LOW.
- WAIT_RDY_LOW, ready_in=0:
  - If byte_count == RAM_BYTES, go to WAIT_DONE; otherwise go to WAIT_RDY.
  - A ready held high counts once only.
- WAIT_DONE, done_in=1: go to DONE; programming deasserts on the same edge; prog_data holds its last value.
- done_in=1 in ARM, WAIT_RDY or WAIT_RDY_LOW (early done): go to ERROR.
- Timeout:
  - Counter clears on every state change and increments each cycle in a wait state.
  - Reaching TIMEOUT goes to ERROR.
- ERROR: programming=0. byte_count freezes and reports progress at failure.
- Simultaneous events:
  - done_in and ready_in together in WAIT_RDY: the error has priority.
  - img_we together with start in IDLE: the write completes first; the load reads the new value.
- rst mid-load: state returns to IDLE next edge; programming drops immediately on that edge; the image is kept.
- Wrap-around: after RAM_BYTES bytes the pointer is back at 0; byte_count reaches RAM_BYTES and never wraps.

Test Plan:
- Full load:
  - Stimulus: write image[i]=i*17; pulse start; model CPU pulses ready_in for 2 cycles with 3-cycle gaps, 16 times, then done_in=1.
  - Required: prog_data = 0x00, 0x11, …, 0xFF in order at each ready; byte_count=16; done=1; programming=0.
- Held ready: keep ready_in high for 10 cycles on the first byte -> byte_count=1, pointer=1, prog_data=image[1].
- Early done: assert done_in after 5 bytes -> error=1, programming=0, byte_count=5.
- Timeout: TIMEOUT=20, never assert ready -> error=1 exactly 20 cycles after entering WAIT_RDY.
- Reset mid-load: assert rst after 7 bytes -> next edge IDLE, all outputs zero; new start reloads from image[0] with the image intact.
- Write lockout: img_we to addr 3 with 0xAA while busy -> ignored; a second load still presents the original image[3].
